// File: rtl/keypad_pkg.sv
// Shared types and constants for the keypad time-entry path: state encoding,
// BCD digit limits and the 4-digit MM:SS time vector with its BCD decrement.
package keypad_pkg;

    localparam int DIGIT_W      = 4;
    localparam int NUM_DIGITS   = 4;
    localparam int BCD_MAX      = 9;
    localparam int SEC_TENS_MAX = 5;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        PAUSE = 2'd2
    } state_e;

    // Index 3 = min_tens, 2 = min_ones, 1 = sec_tens, 0 = sec_ones.
    typedef logic [NUM_DIGITS-1:0][DIGIT_W-1:0] time_t;

    function automatic logic time_is_zero(input time_t t);
        return (t == '0);
    endfunction

    // Ripple borrow digit by digit; an entered sec_tens above 5 simply counts
    // down from wherever it is, only a borrow into sec_tens reloads it to 5.
    function automatic time_t bcd_dec(input time_t t);
        time_t r;
        r = t;
        if (!time_is_zero(t)) begin
            if (t[0] != '0) begin
                r[0] = t[0] - 1'b1;
            end else begin
                r[0] = DIGIT_W'(BCD_MAX);
                if (t[1] != '0) begin
                    r[1] = t[1] - 1'b1;
                end else begin
                    r[1] = DIGIT_W'(SEC_TENS_MAX);
                    if (t[2] != '0) begin
                        r[2] = t[2] - 1'b1;
                    end else begin
                        r[2] = DIGIT_W'(BCD_MAX);
                        r[3] = t[3] - 1'b1;
                    end
                end
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/key_sync.sv
// Brings the encoder's asynchronous loadn/D into the clk domain and turns each
// low period of loadn into exactly one press event.
module key_sync
    import keypad_pkg::*;
#(
    parameter int SYNC_STAGES      = 2,
    parameter int MIN_PRESS_CYCLES = 1
) (
    input  logic               clk,
    input  logic               resetn,
    input  logic               loadn,
    input  logic [DIGIT_W-1:0] D,
    output logic               press_valid,
    output logic [DIGIT_W-1:0] press_digit
);

    localparam int CNT_W = (MIN_PRESS_CYCLES < 2) ? 1 : $clog2(MIN_PRESS_CYCLES + 1);

    logic [SYNC_STAGES-1:0]              loadn_sync_q, loadn_sync_d;
    logic [SYNC_STAGES-1:0][DIGIT_W-1:0] d_sync_q, d_sync_d;
    logic [SYNC_STAGES-1:0]              fill_q, fill_d;
    logic [CNT_W-1:0]                    cnt_q, cnt_d;
    logic                                armed_q, armed_d;
    logic                                loadn_s;
    logic                                live;

    assign loadn_s     = loadn_sync_q[SYNC_STAGES-1];
    assign press_digit = d_sync_q[SYNC_STAGES-1];
    // The chain's reset value of 1 is not a real observation of loadn; only
    // arm once every stage holds a sample taken after reset released.
    assign live        = fill_q[SYNC_STAGES-1];

    always_comb begin
        loadn_sync_d = {loadn_sync_q[SYNC_STAGES-2:0], loadn};
        d_sync_d     = {d_sync_q[SYNC_STAGES-2:0], D};
        fill_d       = {fill_q[SYNC_STAGES-2:0], 1'b1};
        cnt_d        = cnt_q;
        armed_d      = armed_q;
        press_valid  = 1'b0;
        if (live && loadn_s) begin
            armed_d = 1'b1;
            cnt_d   = '0;
        end else if (live && armed_q) begin
            if (cnt_q == CNT_W'(MIN_PRESS_CYCLES - 1)) begin
                press_valid = 1'b1;
                armed_d     = 1'b0;
                cnt_d       = '0;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            loadn_sync_q <= '1;
            d_sync_q     <= '0;
            fill_q       <= '0;
            cnt_q        <= '0;
            armed_q      <= 1'b0;
        end else begin
            loadn_sync_q <= loadn_sync_d;
            d_sync_q     <= d_sync_d;
            fill_q       <= fill_d;
            cnt_q        <= cnt_d;
            armed_q      <= armed_d;
        end
    end

endmodule

// File: rtl/keypad_time_entry.sv
// MM:SS entry register fed by keypad presses, with a start/stop/clear
// countdown on the 1 Hz tick and keypad lockout while a cycle is active.
module keypad_time_entry
    import keypad_pkg::*;
#(
    parameter int SYNC_STAGES      = 2,
    parameter int MIN_PRESS_CYCLES = 1
) (
    input  logic               clk,
    input  logic               resetn,
    input  logic [DIGIT_W-1:0] D,
    input  logic               loadn,
    input  logic               start,
    input  logic               stop,
    input  logic               clear,
    input  logic               tick_1hz,
    output logic               enablen,
    output logic [DIGIT_W-1:0] min_tens,
    output logic [DIGIT_W-1:0] min_ones,
    output logic [DIGIT_W-1:0] sec_tens,
    output logic [DIGIT_W-1:0] sec_ones,
    output logic               running,
    output logic               done
);

    state_e             state_q, state_d;
    time_t              time_q, time_d, time_dec;
    logic               done_q, done_d;
    logic               running_q, running_d;
    logic               enablen_q, enablen_d;
    logic               press_valid;
    logic [DIGIT_W-1:0] press_digit;

    key_sync #(
        .SYNC_STAGES      (SYNC_STAGES),
        .MIN_PRESS_CYCLES (MIN_PRESS_CYCLES)
    ) u_key_sync (
        .clk         (clk),
        .resetn      (resetn),
        .loadn       (loadn),
        .D           (D),
        .press_valid (press_valid),
        .press_digit (press_digit)
    );

    assign time_dec = bcd_dec(time_q);

    // Only the highest-priority asserted input acts in a given cycle:
    // clear > stop > start > tick > press.
    always_comb begin
        state_d = state_q;
        time_d  = time_q;
        done_d  = 1'b0;
        if (clear) begin
            time_d  = '0;
            state_d = IDLE;
        end else if (stop) begin
            if (state_q == RUN) state_d = PAUSE;
        end else if (start) begin
            if (state_q == PAUSE || (state_q == IDLE && !time_is_zero(time_q)))
                state_d = RUN;
        end else if (tick_1hz) begin
            if (state_q == RUN && !time_is_zero(time_q)) begin
                time_d = time_dec;
                if (time_is_zero(time_dec)) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end
            end
        end else if (press_valid && state_q == IDLE && press_digit <= DIGIT_W'(BCD_MAX)) begin
            time_d = {time_q[NUM_DIGITS-2:0], press_digit};
        end
        running_d = (state_d == RUN);
        enablen_d = (state_d != IDLE);
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q   <= IDLE;
            time_q    <= '0;
            done_q    <= 1'b0;
            running_q <= 1'b0;
            enablen_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            time_q    <= time_d;
            done_q    <= done_d;
            running_q <= running_d;
            enablen_q <= enablen_d;
        end
    end

    assign min_tens = time_q[3];
    assign min_ones = time_q[2];
    assign sec_tens = time_q[1];
    assign sec_ones = time_q[0];
    assign running  = running_q;
    assign enablen  = enablen_q;
    assign done     = done_q;

endmodule

// File: tb/tb_keypad_time_entry.sv
// Directed plus randomized bench for keypad_time_entry against a behavioural
// MM:SS model working in plain integer minutes/seconds.
module tb_keypad_time_entry;

    logic       clk = 1'b0;
    logic       resetn, loadn, start, stop, clear, tick_1hz;
    logic [3:0] D;
    logic       enablen, running, done;
    logic [3:0] min_tens, min_ones, sec_tens, sec_ones;

    keypad_time_entry dut (
        .clk(clk), .resetn(resetn), .D(D), .loadn(loadn), .start(start),
        .stop(stop), .clear(clear), .tick_1hz(tick_1hz), .enablen(enablen),
        .min_tens(min_tens), .min_ones(min_ones), .sec_tens(sec_tens),
        .sec_ones(sec_ones), .running(running), .done(done)
    );

    always #5 clk = ~clk;

    localparam int M_IDLE = 0, M_RUN = 1, M_PAUSE = 2;

    int n_chk = 0, n_err = 0;
    int m_dig [4];      // 3 = min_tens ... 0 = sec_ones
    int m_state = M_IDLE;
    int m_done = 0;
    int done_seen = 0;

    always @(negedge clk) if (done === 1'b1) done_seen++;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] m_time();
        return 32'(m_dig[3] * 4096 + m_dig[2] * 256 + m_dig[1] * 16 + m_dig[0]);
    endfunction

    function automatic logic [31:0] dut_time();
        return {16'h0, min_tens, min_ones, sec_tens, sec_ones};
    endfunction

    function automatic bit m_zero();
        return (m_dig[0] + m_dig[1] + m_dig[2] + m_dig[3]) == 0;
    endfunction

    task automatic m_reset();
        for (int i = 0; i < 4; i++) m_dig[i] = 0;
        m_state = M_IDLE;
    endtask

    // One cycle of the model; inputs are considered in priority order.
    task automatic m_step(input bit c, input bit sp, input bit st, input bit tk,
                          input bit pr, input int d);
        int sec, mins;
        if (c) begin
            m_reset();
        end else if (sp) begin
            if (m_state == M_RUN) m_state = M_PAUSE;
        end else if (st) begin
            if (m_state == M_PAUSE || (m_state == M_IDLE && !m_zero())) m_state = M_RUN;
        end else if (tk) begin
            if (m_state == M_RUN && !m_zero()) begin
                sec  = m_dig[1] * 10 + m_dig[0];
                mins = m_dig[3] * 10 + m_dig[2];
                if (sec > 0) sec--;
                else begin sec = 59; mins--; end
                m_dig[0] = sec % 10;  m_dig[1] = sec / 10;
                m_dig[2] = mins % 10; m_dig[3] = mins / 10;
                if (m_zero()) begin m_state = M_IDLE; m_done++; end
            end
        end else if (pr && m_state == M_IDLE && d <= 9) begin
            for (int i = 3; i > 0; i--) m_dig[i] = m_dig[i-1];
            m_dig[0] = d;
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_all(input string tag);
        chk({tag, "_time"}, dut_time(), m_time());
        chk({tag, "_run"}, 32'(running), 32'(m_state == M_RUN));
        chk({tag, "_en"}, 32'(enablen), 32'(m_state != M_IDLE));
        chk({tag, "_done"}, 32'(done_seen), 32'(m_done));
    endtask

    task automatic pulse(input bit c, input bit sp, input bit st, input bit tk);
        clear = c; stop = sp; start = st; tick_1hz = tk;
        cyc();
        clear = 0; stop = 0; start = 0; tick_1hz = 0;
        m_step(c, sp, st, tk, 0, 0);
        cyc();
    endtask

    task automatic press_key(input int d, input int low, input int high);
        D = 4'(d);
        loadn = 1'b0;
        repeat (low) cyc();
        loadn = 1'b1;
        repeat (high) cyc();
        repeat (3) cyc();
        m_step(0, 0, 0, 0, 1, d);
    endtask

    task automatic enter4(input int a, input int b, input int c, input int d);
        press_key(a, 5, 5); press_key(b, 5, 5); press_key(c, 5, 5); press_key(d, 5, 5);
    endtask

    initial begin
        int op, bits;
        resetn = 0; loadn = 1; D = 0; start = 0; stop = 0; clear = 0; tick_1hz = 0;
        m_reset();
        #2;
        chk("rst_time", dut_time(), 32'h0);
        chk("rst_en", 32'(enablen), 32'h0);
        chk("rst_run", 32'(running), 32'h0);
        chk("rst_done", 32'(done), 32'h0);
        repeat (2) cyc();
        resetn = 1;
        repeat (4) cyc();

        // Press latency: digit appears on the third edge after loadn sampled low.
        D = 4'd1; loadn = 1'b0;
        cyc(); cyc();
        chk("lat_edge2", dut_time(), 32'h0);
        cyc();
        chk("lat_edge3", dut_time(), 32'h1);
        loadn = 1'b1;
        repeat (5) cyc();
        m_step(0, 0, 0, 0, 1, 1);

        press_key(2, 5, 5); press_key(3, 5, 5); press_key(0, 5, 5);
        chk_all("entry_1230");
        press_key(5, 5, 5);
        chk_all("entry_2305");
        press_key(6, 20, 5);
        chk_all("held_low");
        press_key(10, 5, 5);
        chk_all("invalid_A");

        // Borrow across the minute boundary, keypad locked in RUN.
        pulse(1, 0, 0, 0);
        enter4(0, 1, 0, 0);
        pulse(0, 0, 1, 0);
        pulse(0, 0, 0, 1);
        chk("borrow_0059", dut_time(), 32'h0059);
        chk_all("borrow");
        press_key(7, 5, 5);
        chk_all("run_press_ignored");

        // Completion: done for exactly one cycle, back to IDLE.
        pulse(1, 0, 0, 0);
        enter4(0, 0, 0, 2);
        pulse(0, 0, 1, 0);
        pulse(0, 0, 0, 1);
        chk("cmpl_0001", dut_time(), 32'h0001);
        tick_1hz = 1;
        cyc();
        tick_1hz = 0;
        m_step(0, 0, 0, 1, 0, 0);
        chk("cmpl_done_hi", 32'(done), 32'h1);
        chk("cmpl_en", 32'(enablen), 32'h0);
        cyc();
        chk("cmpl_done_lo", 32'(done), 32'h0);
        pulse(0, 0, 0, 1);
        pulse(0, 0, 0, 1);
        chk_all("cmpl_after");

        // Same-cycle priority.
        enter4(0, 0, 1, 0);
        pulse(0, 0, 1, 0);
        pulse(0, 1, 0, 1);
        chk("prio_stop_tick", dut_time(), 32'h0010);
        chk_all("prio_pause");
        pulse(0, 0, 1, 0);
        chk_all("prio_resume");
        pulse(1, 0, 1, 0);
        chk_all("prio_clear_start");

        // Raw count-down of an out-of-range seconds entry.
        enter4(0, 0, 9, 9);
        pulse(0, 0, 1, 0);
        pulse(0, 0, 0, 1);
        chk("raw_0098", dut_time(), 32'h0098);
        pulse(1, 0, 0, 0);

        for (int it = 0; it < 80; it++) begin
            op = int'($urandom_range(0, 11));
            if (op <= 3) begin
                press_key(int'($urandom_range(0, 11)), int'($urandom_range(1, 6)),
                          int'($urandom_range(1, 4)));
            end else if (op <= 5) pulse(0, 0, 1, 0);
            else if (op == 6) pulse(0, 1, 0, 0);
            else if (op <= 10) pulse(0, 0, 0, 1);
            else begin
                bits = int'($urandom_range(0, 15));
                if (bits[3] && $urandom_range(0, 3) != 0) bits[3] = 1'b0;
                pulse(bits[3], bits[2], bits[1], bits[0]);
            end
            chk_all($sformatf("rnd%0d", it));
        end

        // Asynchronous reset mid-run, loadn held low through the release.
        pulse(1, 0, 0, 0);
        enter4(0, 5, 0, 0);
        pulse(0, 0, 1, 0);
        D = 4'd3; loadn = 1'b0;
        @(posedge clk); #3;
        resetn = 0;
        #1;
        chk("mid_rst_time", dut_time(), 32'h0);
        chk("mid_rst_en", 32'(enablen), 32'h0);
        chk("mid_rst_run", 32'(running), 32'h0);
        chk("mid_rst_done", 32'(done), 32'h0);
        m_reset();
        cyc();
        resetn = 1;
        repeat (10) cyc();
        chk_all("held_after_rst");
        loadn = 1'b1;
        repeat (5) cyc();
        press_key(4, 5, 5);
        chk_all("press_after_rst");

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
